audio_clock_regeneration_decoder: RTL and testbench
===================================================

AUDIO_CLOCK_REGENERATION_DECODER -- requirements
Module: audio_clock_regeneration_decoder

Interface
REQ-001 SHALL have parameter CTS_TOLERANCE, default 4, the maximum |CTS - reference CTS| still counted as a match.
REQ-002 SHALL have parameter LOCK_COUNT, default 2, the number of consecutive matching packets needed to lock (range 1..15).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the number of clk_pixel cycles without a valid packet before lock is dropped.
REQ-004 SHALL have port clk_pixel, input, 1, the sole clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port packet_valid, input, 1, a one-cycle strobe qualifying header/sub.
REQ-007 SHALL have port header, input, 24, packet header; HB0 = header[7:0].
REQ-008 SHALL have port sub, input, 4 x 56 (unpacked [3:0]), the four subpackets.
REQ-009 SHALL have port n_value, output, 20, the last accepted N.
REQ-010 SHALL have port cts_value, output, 20, the last accepted CTS.
REQ-011 SHALL have port locked, output, 1, high while in the LOCKED state.
REQ-012 SHALL have port acr_error, output, 1, a one-cycle pulse on a malformed ACR packet.
REQ-013 SHALL have port tick_128fs, output, 1, a one-cycle pulse at the regenerated 128*fs rate.
REQ-014 SHALL have port sample_strobe, output, 1, a one-cycle pulse at the regenerated fs rate.

Function
REQ-015 SHALL treat a cycle with packet_valid=1 and header[7:0]=8'h01 as an ACR packet; HB1 and HB2 are ignored, and packets with any other HB0 are ignored entirely.
REQ-016 SHALL extract fields from sub[0] as follows: N = {sub[35:32], sub[47:40], sub[55:48]}; CTS = {sub[11:8], sub[23:16], sub[31:24]}.
REQ-017 SHALL classify an ACR packet as malformed if any of these hold: sub[1..3] != sub[0]; sub[39:36] != 0; sub[15:12] != 0; sub[7:0] != 0; N = 0; CTS = 0; N >= CTS.
REQ-018 SHALL, for a malformed packet at cycle t, pulse acr_error at t+1 and leave n_value, cts_value, the FSM and the timeout counter unchanged.
REQ-019 SHALL, for a well-formed packet at cycle t, register n_value/cts_value at t+1 and clear the timeout counter.
REQ-020 SHALL implement FSM states UNLOCKED, ACQUIRE and LOCKED with match_cnt 4 bits wide.
REQ-021 SHALL, in UNLOCKED on a valid packet, go to ACQUIRE with match_cnt=1, or go directly to LOCKED if LOCK_COUNT=1.
REQ-022 SHALL define a match as N equal to the previous accepted N and |CTS - previous CTS| <= CTS_TOLERANCE, computed at 21 bits signed.
REQ-023 SHALL, in ACQUIRE, increment match_cnt on a match and enter LOCKED when match_cnt reaches LOCK_COUNT; on a mismatch it SHALL set match_cnt=1 and stay in ACQUIRE.
REQ-024 SHALL, in LOCKED, stay LOCKED on a match and go to ACQUIRE with match_cnt=1 on a mismatch.
REQ-025 SHALL go to UNLOCKED from ACQUIRE or LOCKED when the timeout counter reaches TIMEOUT_CYCLES; a timeout coinciding with a valid packet yields to the packet.
REQ-026 SHALL keep a 21-bit accumulator acc: each LOCKED cycle, s = acc + n_value; if s >= cts_value then acc <= s - cts_value and tick_128fs=1 next cycle, else acc <= s.
REQ-027 SHALL clear acc to 0 whenever cts_value or n_value is written, and whenever the FSM is not LOCKED; tick_128fs SHALL be 0 when not LOCKED.
REQ-028 SHALL keep a 7-bit tick counter incremented per tick_128fs; sample_strobe SHALL pulse coincident with the tick that wraps it 127->0; the counter SHALL clear when not LOCKED.
REQ-029 SHALL make locked a registered copy of (state == LOCKED), asserted on the same cycle the state changes.

Reset
REQ-030 SHALL, on synchronous reset=1, force state=UNLOCKED, match_cnt=0, acc=0, tick counter=0, timeout counter=0, n_value=0, cts_value=0, locked=0, acr_error=0, tick_128fs=0 and sample_strobe=0.
REQ-031 SHALL give reset priority over a simultaneous packet_valid, discarding that packet.

Verification
REQ-032 Two valid packets N=6144, CTS=25200 -> locked=1 one cycle after the second packet; thereafter exactly 6144 tick_128fs and 48 sample_strobe per 25200 cycles.
REQ-033 Locked, then packet CTS=25203 -> stays locked, acc cleared; then packet CTS=25210 -> locked=0, state ACQUIRE, ticks stop.
REQ-034 Packet with sub[2][31:24] differing, or with N=30000, CTS=25200 -> acr_error single pulse; n_value, cts_value and locked unchanged.
REQ-035 Locked, TIMEOUT_CYCLES=1000, no packets for 1000 cycles -> locked=0 and tick_128fs=0 from the next cycle.
REQ-036 Reset asserted mid-LOCKED together with packet_valid -> all outputs 0 next cycle; two fresh packets are needed to relock.
REQ-037 Packet with HB0=8'h02 carrying valid ACR payload -> no effect, no acr_error.

Source files
------------

// File: rtl/audio_clock_regeneration_decoder.sv
// Audio Clock Regeneration decoder: validates ACR packets, locks on a
// stable N/CTS pair and regenerates 128*fs ticks and an fs sample strobe.
//
// Ports:
//   clk_pixel      - sole clock, rising edge
//   reset          - synchronous active-high reset
//   packet_valid   - one-cycle strobe qualifying header/sub
//   header[23:0]   - packet header, HB0 = header[7:0]
//   sub[3:0][55:0] - the four subpackets
//   n_value        - last accepted N
//   cts_value      - last accepted CTS
//   locked         - high while the lock FSM is LOCKED
//   acr_error      - one-cycle pulse on a malformed ACR packet
//   tick_128fs     - one-cycle pulse at 128*fs
//   sample_strobe  - one-cycle pulse at fs
module audio_clock_regeneration_decoder #(
    parameter int unsigned CTS_TOLERANCE  = 4,
    parameter int unsigned LOCK_COUNT     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        packet_valid,
    input  logic [23:0] header,
    input  logic [55:0] sub [3:0],
    output logic [19:0] n_value,
    output logic [19:0] cts_value,
    output logic        locked,
    output logic        acr_error,
    output logic        tick_128fs,
    output logic        sample_strobe
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0] LC = 4'(LOCK_COUNT);
    localparam logic [20:0] TOL = 21'(CTS_TOLERANCE);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ACQUIRE,
        ST_LOCKED
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    match_cnt_q, match_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [19:0]   n_q, n_d;
    logic [19:0]   cts_q, cts_d;
    logic [20:0]   acc_q, acc_d;
    logic [6:0]    tcnt_q, tcnt_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic          tick_q, tick_d;
    logic          strobe_q, strobe_d;

    logic               is_acr;
    logic               malformed;
    logic               accept;
    logic               is_match;
    logic               run;
    logic [19:0]        pkt_n;
    logic [19:0]        pkt_cts;
    logic signed [20:0] cts_diff;
    logic [20:0]        cts_abs;
    logic [20:0]        acc_sum;
    logic               unused_hdr;

    // HB1/HB2 carry nothing this block needs.
    assign unused_hdr = ^header[23:8];

    assign is_acr  = packet_valid && (header[7:0] == 8'h01);
    assign pkt_n   = {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
    assign pkt_cts = {sub[0][11:8], sub[0][23:16], sub[0][31:24]};

    assign malformed = (sub[1] != sub[0]) || (sub[2] != sub[0]) ||
                       (sub[3] != sub[0]) ||
                       (sub[0][39:36] != 4'd0) ||
                       (sub[0][15:12] != 4'd0) ||
                       (sub[0][7:0] != 8'd0) ||
                       (pkt_n == 20'd0) || (pkt_cts == 20'd0) ||
                       (pkt_n >= pkt_cts);

    assign accept = is_acr && !malformed;

    // Signed 21-bit difference so the absolute value never overflows.
    assign cts_diff = $signed({1'b0, pkt_cts}) - $signed({1'b0, cts_q});
    assign cts_abs  = cts_diff[20] ? (~cts_diff + 21'd1) : cts_diff;
    assign is_match = (pkt_n == n_q) && (cts_abs <= TOL);

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        tmo_d       = tmo_q;
        if (accept) begin
            tmo_d = '0;
            case (state_q)
                ST_UNLOCKED: begin
                    match_cnt_d = 4'd1;
                    state_d = (LC == 4'd1) ? ST_LOCKED : ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (is_match) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if ((match_cnt_q + 4'd1) >= LC)
                            state_d = ST_LOCKED;
                    end else begin
                        match_cnt_d = 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!is_match) begin
                        state_d     = ST_ACQUIRE;
                        match_cnt_d = 4'd1;
                    end
                end
                default: begin
                    state_d     = ST_UNLOCKED;
                    match_cnt_d = 4'd0;
                end
            endcase
        end else if (!is_acr) begin
            // A malformed packet freezes the counter; idle cycles count.
            if (tmo_q != TMAX)
                tmo_d = tmo_q + TW'(1);
            if (tmo_d == TMAX && state_q != ST_UNLOCKED) begin
                state_d     = ST_UNLOCKED;
                match_cnt_d = 4'd0;
            end
        end
    end

    // Accumulate only across cycles that stay LOCKED with no rewrite,
    // so a tick is never emitted after lock is lost.
    assign run     = (state_q == ST_LOCKED) && (state_d == ST_LOCKED) &&
                     !accept;
    assign acc_sum = acc_q + {1'b0, n_q};

    always_comb begin
        n_d      = accept ? pkt_n : n_q;
        cts_d    = accept ? pkt_cts : cts_q;
        acc_d    = '0;
        tick_d   = 1'b0;
        tcnt_d   = tcnt_q;
        strobe_d = 1'b0;
        if (run) begin
            if (acc_sum >= {1'b0, cts_q}) begin
                acc_d  = acc_sum - {1'b0, cts_q};
                tick_d = 1'b1;
            end else begin
                acc_d = acc_sum;
            end
        end
        if (state_d != ST_LOCKED) begin
            tcnt_d = '0;
        end else if (tick_d) begin
            tcnt_d   = tcnt_q + 7'd1;
            strobe_d = (tcnt_q == 7'd127);
        end
        locked_d = (state_d == ST_LOCKED);
        err_d    = is_acr && malformed;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q     <= ST_UNLOCKED;
            match_cnt_q <= '0;
            tmo_q       <= '0;
            n_q         <= '0;
            cts_q       <= '0;
            acc_q       <= '0;
            tcnt_q      <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            tick_q      <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            tmo_q       <= tmo_d;
            n_q         <= n_d;
            cts_q       <= cts_d;
            acc_q       <= acc_d;
            tcnt_q      <= tcnt_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            tick_q      <= tick_d;
            strobe_q    <= strobe_d;
        end
    end

    assign n_value       = n_q;
    assign cts_value     = cts_q;
    assign locked        = locked_q;
    assign acr_error     = err_q;
    assign tick_128fs    = tick_q;
    assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_audio_clock_regeneration_decoder.sv
// Bench for the ACR decoder: directed scenarios plus random traffic,
// all checked cycle by cycle against an arithmetic reference model.
module tb_audio_clock_regeneration_decoder;

    localparam int TOL  = 4;
    localparam int LCNT = 2;
    localparam int TMO  = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pv;
    logic [23:0] hdr;
    logic [55:0] sub [3:0];
    logic [19:0] n_value, cts_value;
    logic        locked, acr_error, tick_128fs, sample_strobe;

    audio_clock_regeneration_decoder #(
        .CTS_TOLERANCE (TOL),
        .LOCK_COUNT    (LCNT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_pixel    (clk),
        .reset        (rst),
        .packet_valid (pv),
        .header       (hdr),
        .sub          (sub),
        .n_value      (n_value),
        .cts_value    (cts_value),
        .locked       (locked),
        .acr_error    (acr_error),
        .tick_128fs   (tick_128fs),
        .sample_strobe(sample_strobe)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_seen = 0;
    int strobe_seen = 0;

    // Reference model state: 0 unlocked, 1 acquiring, 2 locked.
    int     m_st, m_mc, m_tmo, m_tc;
    longint m_n, m_c, m_k;
    bit     e_tick, e_strobe, e_err, e_locked;

    task automatic check(input string tag, input logic [39:0] got,
                         input logic [39:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] pk(input int n, input int c);
        logic [19:0] nn, cc;
        nn = 20'(n);
        cc = 20'(c);
        return {nn[7:0], nn[15:8], 4'd0, nn[19:16],
                cc[7:0], cc[15:8], 4'd0, cc[19:16], 8'd0};
    endfunction

    task automatic model_step(input bit r, input bit v,
                              input logic [23:0] h,
                              input logic [55:0] s0, s1, s2, s3);
        bit     acr, bad, wr, match, run;
        longint pn, pc, d;
        int     nst;
        if (r) begin
            m_st = 0; m_mc = 0; m_tmo = 0; m_tc = 0;
            m_n = 0; m_c = 0; m_k = 0;
            e_tick = 0; e_strobe = 0; e_err = 0; e_locked = 0;
            return;
        end
        acr = v && (h[7:0] == 8'h01);
        pn  = longint'({s0[35:32], s0[47:40], s0[55:48]});
        pc  = longint'({s0[11:8], s0[23:16], s0[31:24]});
        bad = (s1 != s0) || (s2 != s0) || (s3 != s0) ||
              (s0[39:36] != 0) || (s0[15:12] != 0) || (s0[7:0] != 0) ||
              (pn == 0) || (pc == 0) || (pn >= pc);
        wr    = acr && !bad;
        e_err = acr && bad;
        nst   = m_st;
        if (wr) begin
            d = pc - m_c;
            if (d < 0) d = -d;
            match = (pn == m_n) && (d <= TOL);
            if (m_st == 0) begin
                m_mc = 1;
                nst = (LCNT == 1) ? 2 : 1;
            end else if (match) begin
                if (m_st == 1) begin
                    m_mc++;
                    if (m_mc >= LCNT) nst = 2;
                end
            end else begin
                m_mc = 1;
                nst = 1;
            end
            m_tmo = 0;
            m_n = pn;
            m_c = pc;
        end else if (!acr) begin
            if (m_tmo < TMO) m_tmo++;
            if (m_tmo == TMO && m_st != 0) begin
                nst = 0;
                m_mc = 0;
            end
        end
        // Ticks come from floor(k*N/CTS) stepping since the last clear.
        run = (m_st == 2) && (nst == 2) && !wr;
        if (run) begin
            m_k++;
            e_tick = ((m_k * m_n) / m_c) != (((m_k - 1) * m_n) / m_c);
        end else begin
            m_k = 0;
            e_tick = 0;
        end
        e_strobe = 0;
        if (nst != 2) begin
            m_tc = 0;
        end else if (e_tick) begin
            m_tc = (m_tc + 1) % 128;
            e_strobe = (m_tc == 0);
        end
        m_st = nst;
        e_locked = (nst == 2);
    endtask

    task automatic cycle(input bit r, input bit v, input logic [23:0] h,
                         input logic [55:0] s0, s1, s2, s3);
        rst = r; pv = v; hdr = h;
        sub[0] = s0; sub[1] = s1; sub[2] = s2; sub[3] = s3;
        @(posedge clk);
        #1;
        model_step(r, v, h, s0, s1, s2, s3);
        check("n_value", 40'(n_value), 40'(m_n));
        check("cts_value", 40'(cts_value), 40'(m_c));
        check("locked", 40'(locked), 40'(e_locked));
        check("acr_error", 40'(acr_error), 40'(e_err));
        check("tick_128fs", 40'(tick_128fs), 40'(e_tick));
        check("sample_strobe", 40'(sample_strobe), 40'(e_strobe));
        tick_seen += int'(tick_128fs);
        strobe_seen += int'(sample_strobe);
    endtask

    task automatic idle(input int nc);
        for (int i = 0; i < nc; i++)
            cycle(0, 0, 24'h0, 56'h0, 56'h0, 56'h0, 56'h0);
    endtask

    task automatic send(input int n, input int c);
        logic [55:0] s;
        s = pk(n, c);
        cycle(0, 1, {16'($urandom()), 8'h01}, s, s, s, s);
    endtask

    initial begin
        logic [55:0] s, t;
        int rn, rc, n, c, sel, kind;

        cycle(1, 0, 24'h0, 56'h0, 56'h0, 56'h0, 56'h0);
        cycle(1, 1, 24'h01, pk(10, 20), pk(10, 20), pk(10, 20), pk(10, 20));
        check("rst_n", 40'(n_value), 40'd0);
        check("rst_locked", 40'(locked), 40'd0);
        check("rst_tick", 40'(tick_128fs), 40'd0);

        // Lock on 6144/25200 and count regenerated ticks.
        send(6144, 25200);
        check("one_pkt_unlocked", 40'(locked), 40'd0);
        idle(3);
        send(6144, 25200);
        check("lock_2nd", 40'(locked), 40'd1);
        tick_seen = 0; strobe_seen = 0;
        idle(525);
        check("ticks_525", 40'(tick_seen), 40'd128);
        check("strobes_525", 40'(strobe_seen), 40'd1);
        idle(100);

        // Small CTS drift keeps lock, large drift drops it.
        send(6144, 25203);
        check("drift_ok_lock", 40'(locked), 40'd1);
        check("drift_ok_tick", 40'(tick_128fs), 40'd0);
        idle(5);
        send(6144, 25210);
        check("drift_bad_lock", 40'(locked), 40'd0);
        tick_seen = 0;
        idle(10);
        check("drift_bad_ticks", 40'(tick_seen), 40'd0);

        // Relock, then time out after TMO idle cycles.
        send(6144, 25210);
        check("relock", 40'(locked), 40'd1);
        idle(TMO - 1);
        check("tmo_edge_lock", 40'(locked), 40'd1);
        idle(1);
        check("tmo_unlock", 40'(locked), 40'd0);
        tick_seen = 0;
        idle(5);
        check("tmo_ticks", 40'(tick_seen), 40'd0);

        // Malformed packets while locked.
        send(6144, 25200);
        send(6144, 25200);
        s = pk(6144, 25200);
        t = s;
        t[31:24] = t[31:24] ^ 8'h01;
        cycle(0, 1, 24'h01, s, s, t, s);
        check("bad_sub_err", 40'(acr_error), 40'd1);
        check("bad_sub_lock", 40'(locked), 40'd1);
        idle(1);
        check("err_one_pulse", 40'(acr_error), 40'd0);
        s = pk(30000, 25200);
        cycle(0, 1, 24'h01, s, s, s, s);
        check("n_ge_cts_err", 40'(acr_error), 40'd1);
        check("n_ge_cts_n", 40'(n_value), 40'd6144);

        // Non-ACR header is ignored.
        s = pk(1000, 25200);
        cycle(0, 1, 24'h02, s, s, s, s);
        check("hb0_02_n", 40'(n_value), 40'd6144);
        check("hb0_02_err", 40'(acr_error), 40'd0);
        idle(20);

        // Reset together with a packet while locked.
        s = pk(6144, 25200);
        cycle(1, 1, 24'h01, s, s, s, s);
        check("rst_pkt_n", 40'(n_value), 40'd0);
        check("rst_pkt_lock", 40'(locked), 40'd0);
        send(6144, 25200);
        check("rst_first_pkt", 40'(locked), 40'd0);
        send(6144, 25200);
        check("rst_second_pkt", 40'(locked), 40'd1);

        // Random traffic around a slowly changing N/CTS pair.
        rn = 100; rc = 400;
        for (int i = 0; i < 8000; i++) begin
            if (i == 4000) idle(TMO + 50);
            if ($urandom_range(0, 399) == 0) begin
                rn = $urandom_range(20, 200);
                rc = $urandom_range(250, 600);
            end
            sel = $urandom_range(0, 99);
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 240) : rn;
            c = rc + $urandom_range(0, 12) - 6;
            s = pk(n, c);
            if ($urandom_range(0, 1999) == 0) begin
                cycle(1, sel < 50, 24'h01, s, s, s, s);
            end else if (sel < 4) begin
                cycle(0, 1, {16'($urandom()), 8'h01}, s, s, s, s);
            end else if (sel < 6) begin
                kind = $urandom_range(0, 5);
                t = s;
                case (kind)
                    0: t[7:0] = 8'($urandom_range(1, 255));
                    1: t[15:12] = 4'($urandom_range(1, 15));
                    2: t[39:36] = 4'($urandom_range(1, 15));
                    3: t = pk(c + $urandom_range(0, 50), c);
                    4: t = pk(0, c);
                    default: t = s;
                endcase
                if (kind == 5) begin
                    t[55:48] = t[55:48] ^ 8'h80;
                    cycle(0, 1, 24'h01, s, s, s, t);
                end else begin
                    cycle(0, 1, 24'h01, t, t, t, t);
                end
            end else if (sel < 7) begin
                cycle(0, 1, {16'($urandom()), 8'h03}, s, s, s, s);
            end else begin
                idle(1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
